// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store bus unit: access sizes, FSM states,
// and the alignment rule used when a request is accepted.
package lsu_pkg;

    // Access size encoding carried on req_size
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // One access in flight: accept, present on the bus, wait for data, respond
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    // An access is misaligned when its address is not a multiple of its size,
    // or when it is wider than the data bus (max_size is log2 of bus bytes).
    function automatic logic is_misaligned(input logic [2:0] addr_lo,
                                           input logic [1:0] size,
                                           input logic [1:0] max_size);
        logic low_set;
        case (size)
            SZ_B:    low_set = 1'b0;
            SZ_H:    low_set = addr_lo[0];
            SZ_W:    low_set = |addr_lo[1:0];
            default: low_set = |addr_lo;
        endcase
        return low_set || (size > max_size);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for one bus word: extracts and extends load data, and
// shifts store data into its lanes together with the matching write mask.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [$clog2(DW/8)-1:0] off_i,
    input  logic [1:0]              size_i,
    input  logic                    unsigned_i,
    input  logic [DW-1:0]           data_i,
    output logic [DW-1:0]           load_o,
    output logic [DW-1:0]           store_o,
    output logic [DW/8-1:0]         mask_o
);

    localparam int NB = DW / 8;
    localparam int IW = $clog2(DW);

    logic [DW-1:0] shifted;
    logic [IW-1:0] top_bit;
    logic          sign;

    // Load path: move the addressed lanes down to bit 0, then sign/zero extend
    always_comb begin
        shifted = data_i >> {off_i, 3'b000};
        case (size_i)
            SZ_B:    top_bit = IW'(7);
            SZ_H:    top_bit = IW'(15);
            SZ_W:    top_bit = IW'(31);
            default: top_bit = IW'(DW - 1);
        endcase
        sign = shifted[top_bit] & ~unsigned_i;
        for (int i = 0; i < DW; i++) begin
            load_o[i] = (i <= int'(top_bit)) ? shifted[i] : sign;
        end
    end

    // Store path: move LSB-justified data up to its lanes and enable those lanes
    always_comb begin
        store_o = data_i << {off_i, 3'b000};
        for (int j = 0; j < NB; j++) begin
            mask_o[j] = (j >= int'(off_i)) && (j < int'(off_i) + (1 << size_i));
        end
    end

endmodule

// File: rtl/lsu_bus.sv
// Load/store unit bus adapter: accepts one core access at a time, checks
// alignment, drives a single-beat bus request, waits for the response with a
// timeout, and returns extended load data or an error as a one-cycle pulse.
module lsu_bus
    import lsu_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_wen,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    output logic            resp_valid,
    output logic [DW-1:0]   resp_rdata,
    output logic            resp_err,
    output logic            bus_req_valid,
    input  logic            bus_req_ready,
    output logic [AW-1:0]   bus_addr,
    output logic            bus_wen,
    output logic [DW-1:0]   bus_wdata,
    output logic [DW/8-1:0] bus_wmask,
    input  logic            bus_resp_valid,
    input  logic [DW-1:0]   bus_rdata,
    input  logic            bus_resp_err
);

    localparam int          NB       = DW / 8;
    localparam int          OFFW     = $clog2(NB);
    localparam logic [1:0]  MAX_SZ   = (DW == 64) ? SZ_D : SZ_W;
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    lsu_state_e    state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          wen_q, wen_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          timeout;
    logic [DW-1:0] load_data;
    logic [DW-1:0] store_data;
    logic [NB-1:0] store_mask;
    logic [DW-1:0] ld_store_unused;
    logic [NB-1:0] ld_mask_unused;
    logic [DW-1:0] st_load_unused;

    // The cycle whose increment would take the counter to TIMEOUT is the last one
    assign timeout = (cnt_q == CNT_LAST);

    // Next-state, counter, latched fields and handshake outputs
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wen_d         = wen_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        size_d        = size_q;
        uns_d         = uns_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        req_ready     = 1'b0;
        bus_req_valid = 1'b0;
        resp_valid    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    wen_d   = req_wen;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    rdata_d = '0;
                    if (is_misaligned(req_addr[2:0], req_size, MAX_SZ)) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        err_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                bus_req_valid = 1'b1;
                cnt_d         = cnt_q + 16'd1;
                if (timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (bus_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                // A response landing on the timeout cycle still completes the access
                if (bus_resp_valid) begin
                    rdata_d = bus_rdata;
                    err_d   = bus_resp_err;
                    state_d = ST_RESP;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter and access registers; reset abandons any access in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    lsu_align #(.DW(DW)) u_load_align (
        .off_i      (addr_q[OFFW-1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_i     (rdata_q),
        .load_o     (load_data),
        .store_o    (ld_store_unused),
        .mask_o     (ld_mask_unused)
    );

    lsu_align #(.DW(DW)) u_store_align (
        .off_i      (addr_q[OFFW-1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_i     (wdata_q),
        .load_o     (st_load_unused),
        .store_o    (store_data),
        .mask_o     (store_mask)
    );

    // Bus side comes straight from the latched access, so it is stable in REQ
    assign bus_addr  = {addr_q[AW-1:OFFW], {OFFW{1'b0}}};
    assign bus_wen   = wen_q;
    assign bus_wdata = store_data;
    assign bus_wmask = wen_q ? store_mask : '0;

    // Data is only returned for successful loads
    assign resp_err   = resp_valid & err_q;
    assign resp_rdata = (resp_valid && !err_q && !wen_q) ? load_data : '0;

endmodule

// File: tb/tb_lsu_bus.sv
`timescale 1ns/1ps
// Scoreboard bench for lsu_bus: a 32-bit instance (TIMEOUT=4) and a 64-bit
// instance (TIMEOUT=8) share stimulus; one is selected at a time.
module tb_lsu_bus;
    import lsu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, sel;
    logic        req_valid, req_wen, req_unsigned;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_size;
    logic        bus_req_ready, bus_resp_valid, bus_resp_err;
    logic [63:0] bus_rdata;

    logic        a_req_ready, a_resp_valid, a_resp_err, a_bus_req_valid, a_bus_wen;
    logic [31:0] a_resp_rdata, a_bus_addr, a_bus_wdata;
    logic [3:0]  a_bus_wmask;
    logic        b_req_ready, b_resp_valid, b_resp_err, b_bus_req_valid, b_bus_wen;
    logic [63:0] b_resp_rdata, b_bus_wdata;
    logic [31:0] b_bus_addr;
    logic [7:0]  b_bus_wmask;

    logic        o_req_ready, o_resp_valid, o_resp_err, o_bus_req_valid, o_bus_wen;
    logic [63:0] o_resp_rdata, o_bus_wdata;
    logic [31:0] o_bus_addr;
    logic [7:0]  o_bus_wmask;

    lsu_bus #(.DW(32), .AW(32), .TIMEOUT(4)) dut32 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & ~sel), .req_ready(a_req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
        .bus_req_valid(a_bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_addr(a_bus_addr), .bus_wen(a_bus_wen), .bus_wdata(a_bus_wdata),
        .bus_wmask(a_bus_wmask), .bus_resp_valid(bus_resp_valid),
        .bus_rdata(bus_rdata[31:0]), .bus_resp_err(bus_resp_err)
    );

    lsu_bus #(.DW(64), .AW(32), .TIMEOUT(8)) dut64 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & sel), .req_ready(b_req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
        .bus_req_valid(b_bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_addr(b_bus_addr), .bus_wen(b_bus_wen), .bus_wdata(b_bus_wdata),
        .bus_wmask(b_bus_wmask), .bus_resp_valid(bus_resp_valid),
        .bus_rdata(bus_rdata), .bus_resp_err(bus_resp_err)
    );

    assign o_req_ready     = sel ? b_req_ready     : a_req_ready;
    assign o_resp_valid    = sel ? b_resp_valid    : a_resp_valid;
    assign o_resp_err      = sel ? b_resp_err      : a_resp_err;
    assign o_resp_rdata    = sel ? b_resp_rdata    : {32'd0, a_resp_rdata};
    assign o_bus_req_valid = sel ? b_bus_req_valid : a_bus_req_valid;
    assign o_bus_wen       = sel ? b_bus_wen       : a_bus_wen;
    assign o_bus_addr      = sel ? b_bus_addr      : a_bus_addr;
    assign o_bus_wdata     = sel ? b_bus_wdata     : {32'd0, a_bus_wdata};
    assign o_bus_wmask     = sel ? b_bus_wmask     : {4'd0, a_bus_wmask};

    typedef struct {
        int          cyc;
        logic        err;
        logic [63:0] data;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [7:0]  mask;
        logic [63:0] wdata;
    } breq_t;

    resp_t rq[$];
    breq_t bq[$];
    resp_t mon_e;
    breq_t mon_b;
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    bit    prev_bv = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference load result: pick the addressed bytes, then extend to the bus width
    function automatic logic [63:0] model_load(input int dw, input logic [31:0] addr,
                                               input logic [1:0] size, input logic uns,
                                               input logic [63:0] rd);
        logic [127:0] v, m;
        int nb, off;
        nb  = 1 << size;
        off = int'(addr[2:0]) % (dw / 8);
        if (dw == 32) rd = rd & 64'hFFFF_FFFF;
        v = {64'd0, rd} >> (8 * off);
        m = (128'd1 << (8 * nb)) - 128'd1;
        v = v & m;
        if (!uns && v[7'(8 * nb - 1)]) v = v | ~m;
        if (dw == 32) v = v & 128'hFFFF_FFFF;
        return v[63:0];
    endfunction

    // Response monitor
    always @(negedge clk) begin
        if (o_resp_valid) begin
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: resp_valid=1 at cycle %0d, required no response", cyc);
            end else begin
                mon_e = rq.pop_front();
                if (cyc != mon_e.cyc || o_resp_err !== mon_e.err || o_resp_rdata !== mon_e.data) begin
                    errors++;
                    $display("FAIL resp: got cycle=%0d err=%0b rdata=%h, required cycle=%0d err=%0b rdata=%h",
                             cyc, o_resp_err, o_resp_rdata, mon_e.cyc, mon_e.err, mon_e.data);
                end
            end
        end
    end

    // Bus request monitor: every cycle of a request must match the expected beat
    always @(negedge clk) begin
        if (o_bus_req_valid) begin
            checks++;
            if (bq.size() == 0) begin
                errors++;
                $display("FAIL bus_unexpected: bus_req_valid=1 at cycle %0d, required 0", cyc);
            end else begin
                mon_b = bq[0];
                if (o_bus_addr !== mon_b.addr || o_bus_wen !== mon_b.wen || o_bus_wmask !== mon_b.mask ||
                    (mon_b.wen && o_bus_wdata !== mon_b.wdata)) begin
                    errors++;
                    $display("FAIL bus_req: got addr=%h wen=%0b mask=%h wdata=%h, required addr=%h wen=%0b mask=%h wdata=%h",
                             o_bus_addr, o_bus_wen, o_bus_wmask, o_bus_wdata,
                             mon_b.addr, mon_b.wen, mon_b.mask, mon_b.wdata);
                end
            end
        end else if (prev_bv && bq.size() > 0) begin
            void'(bq.pop_front());
        end
        prev_bv = o_bus_req_valid;
    end

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (o_req_ready !== 1'b1 || o_resp_valid !== 1'b0 || o_resp_err !== 1'b0 ||
            o_resp_rdata !== 64'd0 || o_bus_req_valid !== 1'b0 || o_bus_wen !== 1'b0 ||
            o_bus_wmask !== 8'd0 || o_bus_addr !== 32'd0 || o_bus_wdata !== 64'd0) begin
            errors++;
            $display("FAIL %s: ready=%0b rv=%0b err=%0b rdata=%h breq=%0b wen=%0b mask=%h addr=%h wdata=%h, required ready=1 others 0",
                     tag, o_req_ready, o_resp_valid, o_resp_err, o_resp_rdata, o_bus_req_valid,
                     o_bus_wen, o_bus_wmask, o_bus_addr, o_bus_wdata);
        end
    endtask

    // Issue one access: r = cycles bus_req_ready is held low, w = cycles before the response
    task automatic do_txn(input logic wen, input logic [31:0] addr, input logic [63:0] wd,
                          input logic [1:0] size, input logic uns, input int r, input int w,
                          input logic [63:0] rd, input logic berr, input bit rst_in_wait);
        int dw, tmo, nb, off, k;
        bit mis;
        resp_t e;
        breq_t b;
        logic [127:0] sw;
        dw  = sel ? 64 : 32;
        tmo = sel ? 8 : 4;
        nb  = 1 << size;
        off = int'(addr[2:0]) % (dw / 8);
        mis = ((int'(addr[2:0]) % nb) != 0) || (nb > dw / 8);
        k = 0;
        while (!o_req_ready && k < 64) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (!o_req_ready) begin
            errors++;
            $display("FAIL req_ready_wait: req_ready=%0b after %0d cycles, required 1", o_req_ready, k);
            return;
        end
        req_valid    = 1'b1;
        req_wen      = wen;
        req_addr     = addr;
        req_wdata    = wd;
        req_size     = size;
        req_unsigned = uns;
        if (mis) begin
            e.cyc = cyc + 1; e.err = 1'b1; e.data = 64'd0;
            rq.push_back(e);
        end else begin
            b.addr  = addr & ~32'(dw / 8 - 1);
            b.wen   = wen;
            b.mask  = wen ? 8'(((1 << nb) - 1) << off) : 8'h00;
            sw      = {64'd0, (dw == 32) ? (wd & 64'hFFFF_FFFF) : wd} << (8 * off);
            b.wdata = (dw == 32) ? (sw[63:0] & 64'hFFFF_FFFF) : sw[63:0];
            bq.push_back(b);
            if (!rst_in_wait) begin
                if (r + 1 + w < tmo) begin
                    e.cyc  = cyc + r + w + 3;
                    e.err  = berr;
                    e.data = (berr || wen) ? 64'd0 : model_load(dw, addr, size, uns, rd);
                end else begin
                    e.cyc = cyc + 1 + tmo; e.err = 1'b1; e.data = 64'd0;
                end
                rq.push_back(e);
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (o_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL req_ready_busy: req_ready=%0b after accept, required 0", o_req_ready);
        end
        if (!mis) begin
            repeat (r) begin @(posedge clk); #1; end
            bus_req_ready = 1'b1;
            @(posedge clk); #1;
            bus_req_ready = 1'b0;
            if (rst_in_wait) begin
                rst = 1'b1;
                @(posedge clk); #1;
                check_reset_outputs("reset_mid_wait");
                rst = 1'b0;
            end
            repeat (w) begin @(posedge clk); #1; end
            bus_resp_valid = 1'b1;
            bus_rdata      = rd;
            bus_resp_err   = berr;
            @(posedge clk); #1;
            bus_resp_valid = 1'b0;
            bus_resp_err   = 1'b0;
            bus_rdata      = {$urandom, $urandom};
        end
    endtask

    task automatic rand_run(input int n);
        for (int i = 0; i < n; i++) begin
            logic [1:0]  sz;
            logic [31:0] ad, am;
            sz = 2'($urandom_range(0, 3));
            ad = $urandom;
            am = (32'd1 << sz) - 32'd1;
            if ($urandom_range(0, 9) < 8) ad = ad & ~am;
            do_txn(1'($urandom_range(0, 1)), ad, {$urandom, $urandom}, sz,
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                   {$urandom, $urandom}, ($urandom_range(0, 7) == 0), 1'b0);
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; sel = 1'b0;
        req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = '0; req_unsigned = 1'b0;
        bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_err = 1'b0; bus_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset32");
        sel = 1'b1; #1;
        check_reset_outputs("reset64");
        sel = 1'b0; #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // 32-bit instance, directed cases
        do_txn(1'b0, 32'h0000_1003, 64'd0, SZ_B, 1'b0, 0, 0, 64'h80FF_FF12, 1'b0, 1'b0);
        do_txn(1'b0, 32'h0000_1003, 64'd0, SZ_B, 1'b1, 0, 0, 64'h80FF_FF12, 1'b0, 1'b0);
        do_txn(1'b1, 32'h0000_2002, 64'h0000_ABCD, SZ_H, 1'b0, 0, 0, 64'd0, 1'b0, 1'b0);
        do_txn(1'b1, 32'h0000_2002, 64'h0000_ABCD, SZ_H, 1'b0, 3, 0, 64'd0, 1'b0, 1'b0);
        do_txn(1'b0, 32'h0000_3001, 64'd0, SZ_W, 1'b0, 0, 0, 64'd0, 1'b0, 1'b0);
        do_txn(1'b0, 32'h0000_4000, 64'd0, SZ_W, 1'b1, 0, 10, 64'h1234_5678, 1'b0, 1'b0);
        do_txn(1'b0, 32'h0000_5008, 64'd0, SZ_D, 1'b0, 0, 0, 64'd0, 1'b0, 1'b0);
        do_txn(1'b0, 32'h0000_6004, 64'd0, SZ_W, 1'b0, 0, 1, 64'hDEAD_BEEF, 1'b1, 1'b0);
        do_txn(1'b0, 32'h0000_7000, 64'd0, SZ_W, 1'b0, 0, 0, 64'h5555_AAAA, 1'b0, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        rand_run(150);
        repeat (12) @(posedge clk);
        #1;

        // 64-bit instance
        sel = 1'b1; #1;
        do_txn(1'b0, 32'h0000_0008, 64'd0, SZ_D, 1'b0, 0, 0, 64'h8123_4567_89AB_CDEF, 1'b0, 1'b0);
        do_txn(1'b0, 32'h0000_0106, 64'd0, SZ_H, 1'b0, 1, 2, 64'h9876_5432_1000_0000, 1'b0, 1'b0);
        do_txn(1'b1, 32'h0000_2002, 64'h0000_ABCD, SZ_H, 1'b0, 3, 0, 64'd0, 1'b0, 1'b0);
        do_txn(1'b1, 32'h0000_2004, 64'h1122_3344, SZ_W, 1'b0, 0, 0, 64'd0, 1'b0, 1'b0);
        rand_run(150);
        repeat (20) @(posedge clk);
        #1;

        checks++;
        if (rq.size() != 0 || bq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses and %0d bus beats outstanding, required 0 and 0",
                     rq.size(), bq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
